// File: rtl/npn4_canonicalizer_if.sv
// Request/result bundle of the NPN-4 canonicalizer: table in, canonical form and transform out.
// Pure wiring, no latency of its own.
// Request side uses in_valid/in_ready, result side uses out_valid/out_ready.
interface npn4_canonicalizer_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] tt_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] canon_tt;
    logic [4:0]  perm_idx;
    logic [3:0]  neg_mask;
    logic        out_neg;

    // Producer of tables and consumer of results.
    modport master (
        output in_valid,
        output tt_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  canon_tt,
        input  perm_idx,
        input  neg_mask,
        input  out_neg
    );

    // The canonicalizer itself.
    modport slave (
        input  in_valid,
        input  tt_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output canon_tt,
        output perm_idx,
        output neg_mask,
        output out_neg
    );
endinterface

// File: rtl/npn4_canonicalizer.sv
// Maps a 4-input truth table to its NPN class representative (minimum over 768 transforms).
// Latency: 768 cycles from accept edge to out_valid; one transform evaluated per cycle.
// Accepts only when idle; result is held in DONE until out_ready, in_valid ignored meanwhile.
module npn4_canonicalizer (
    input  logic                 clk,
    input  logic                 rst_n,
    npn4_canonicalizer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [9:0] LAST_T = 10'd767;

    state_t      state;
    state_t      state_nxt;

    // Latched input table and the scan index t = k*32 + n*2 + o.
    logic [15:0] tt_q;
    logic [9:0]  t_q;

    // Best transform found so far; these drive the result outputs directly.
    logic [15:0] best_tt;
    logic [4:0]  best_perm;
    logic [3:0]  best_neg;
    logic        best_o;

    // Fields of the current scan index.
    logic [4:0]  cur_k;
    logic [3:0]  cur_n;
    logic        cur_o;

    // Permutation for cur_k, packed as {p3,p2,p1,p0}, two bits each.
    logic [7:0]  cur_perm;

    // Transformed table for the current index and the replace decision.
    logic [15:0] cur_g;
    logic        take;

    logic        accept;
    logic        scan_last;

    assign cur_k     = t_q[9:5];
    assign cur_n     = t_q[4:1];
    assign cur_o     = t_q[0];
    assign accept    = (state == IDLE) && bus.in_valid;
    assign scan_last = (t_q == LAST_T);

    // Pack a permutation (p0,p1,p2,p3) into the ROM word layout.
    function automatic logic [7:0] pk(input logic [1:0] p0, input logic [1:0] p1,
                                      input logic [1:0] p2, input logic [1:0] p3);
        return {p3, p2, p1, p0};
    endfunction

    // Apply (p, n, o): g[m] = f[{y3..y0}] ^ o with y_i = x_{p[i]} ^ n_i.
    function automatic logic [15:0] apply_xform(input logic [15:0] f, input logic [7:0] pr,
                                                input logic [3:0] nm, input logic om);
        logic [15:0] g;
        logic [3:0]  x;
        logic [3:0]  y;
        g = '0;
        x = '0;
        y = '0;
        for (int m = 0; m < 16; m++) begin
            x = 4'(m);
            for (int i = 0; i < 4; i++) begin
                y[i] = x[pr[2*i +: 2]] ^ nm[i];
            end
            g[m] = f[y] ^ om;
        end
        return g;
    endfunction

    // Lexicographic permutation ROM; indices 24..31 are never reached by the scan.
    always_comb begin
        cur_perm = pk(2'd0, 2'd1, 2'd2, 2'd3);
        case (cur_k)
            5'd0:    cur_perm = pk(2'd0, 2'd1, 2'd2, 2'd3);
            5'd1:    cur_perm = pk(2'd0, 2'd1, 2'd3, 2'd2);
            5'd2:    cur_perm = pk(2'd0, 2'd2, 2'd1, 2'd3);
            5'd3:    cur_perm = pk(2'd0, 2'd2, 2'd3, 2'd1);
            5'd4:    cur_perm = pk(2'd0, 2'd3, 2'd1, 2'd2);
            5'd5:    cur_perm = pk(2'd0, 2'd3, 2'd2, 2'd1);
            5'd6:    cur_perm = pk(2'd1, 2'd0, 2'd2, 2'd3);
            5'd7:    cur_perm = pk(2'd1, 2'd0, 2'd3, 2'd2);
            5'd8:    cur_perm = pk(2'd1, 2'd2, 2'd0, 2'd3);
            5'd9:    cur_perm = pk(2'd1, 2'd2, 2'd3, 2'd0);
            5'd10:   cur_perm = pk(2'd1, 2'd3, 2'd0, 2'd2);
            5'd11:   cur_perm = pk(2'd1, 2'd3, 2'd2, 2'd0);
            5'd12:   cur_perm = pk(2'd2, 2'd0, 2'd1, 2'd3);
            5'd13:   cur_perm = pk(2'd2, 2'd0, 2'd3, 2'd1);
            5'd14:   cur_perm = pk(2'd2, 2'd1, 2'd0, 2'd3);
            5'd15:   cur_perm = pk(2'd2, 2'd1, 2'd3, 2'd0);
            5'd16:   cur_perm = pk(2'd2, 2'd3, 2'd0, 2'd1);
            5'd17:   cur_perm = pk(2'd2, 2'd3, 2'd1, 2'd0);
            5'd18:   cur_perm = pk(2'd3, 2'd0, 2'd1, 2'd2);
            5'd19:   cur_perm = pk(2'd3, 2'd0, 2'd2, 2'd1);
            5'd20:   cur_perm = pk(2'd3, 2'd1, 2'd0, 2'd2);
            5'd21:   cur_perm = pk(2'd3, 2'd1, 2'd2, 2'd0);
            5'd22:   cur_perm = pk(2'd3, 2'd2, 2'd0, 2'd1);
            5'd23:   cur_perm = pk(2'd3, 2'd2, 2'd1, 2'd0);
            default: cur_perm = pk(2'd0, 2'd1, 2'd2, 2'd3);
        endcase
    end

    // Evaluate the current transform; t=0 seeds the best registers, later only strict improvements win.
    always_comb begin
        cur_g = apply_xform(tt_q, cur_perm, cur_n, cur_o);
        take  = (t_q == 10'd0) || (cur_g < best_tt);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: accept in IDLE, scan all 768 indices, hold result until consumed.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nxt = SCAN;
            SCAN:    if (scan_last)     state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Job datapath: latch the table on accept, step t and track the minimum while scanning.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tt_q      <= '0;
            t_q       <= '0;
            best_tt   <= '0;
            best_perm <= '0;
            best_neg  <= '0;
            best_o    <= 1'b0;
        end else if (accept) begin
            tt_q <= bus.tt_in;
            t_q  <= '0;
        end else if (state == SCAN) begin
            t_q <= t_q + 10'd1;
            if (take) begin
                best_tt   <= cur_g;
                best_perm <= cur_k;
                best_neg  <= cur_n;
                best_o    <= cur_o;
            end
        end
    end

    // Handshake flags depend on state alone, so out_ready never reaches in_ready combinationally.
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.canon_tt  = best_tt;
    assign bus.perm_idx  = best_perm;
    assign bus.neg_mask  = best_neg;
    assign bus.out_neg   = best_o;

endmodule

// File: tb/tb_npn4_canonicalizer.sv
// Bench for the NPN-4 canonicalizer: vector table plus scoreboard queue of expected results.
// Each job is checked for latency, result fields and the output handshake.
// Back-pressure and mid-scan reset are exercised by hand-written sequences.
module tb_npn4_canonicalizer;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    npn4_canonicalizer_if bus();

    npn4_canonicalizer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [15:0] tt;
        logic [15:0] canon;
        logic [4:0]  perm;
        logic [3:0]  neg;
        logic        oneg;
    } vec_t;

    localparam int NVEC = 10;

    vec_t vecs [NVEC];
    vec_t sb_q [$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Brute-force reference: permutation derived from k by factorial decomposition.
    function automatic vec_t ref_canon(input logic [15:0] f);
        vec_t r;
        bit   first;
        r.tt    = f;
        r.canon = 16'hFFFF;
        r.perm  = '0;
        r.neg   = '0;
        r.oneg  = 1'b0;
        first   = 1'b1;
        for (int k = 0; k < 24; k++) begin
            int avail [4];
            int p [4];
            int fact [4];
            int rem;
            int idx;
            fact[0] = 6; fact[1] = 2; fact[2] = 1; fact[3] = 1;
            for (int j = 0; j < 4; j++) avail[j] = j;
            rem = k;
            for (int i = 0; i < 4; i++) begin
                idx  = rem / fact[i];
                rem  = rem % fact[i];
                p[i] = avail[idx];
                for (int j = idx; j < 3; j++) avail[j] = avail[j+1];
            end
            for (int n = 0; n < 16; n++) begin
                for (int o = 0; o < 2; o++) begin
                    logic [15:0] g;
                    int src;
                    g = '0;
                    for (int m = 0; m < 16; m++) begin
                        src = 0;
                        for (int i = 0; i < 4; i++)
                            src = src | (((((m >> p[i]) & 1) ^ ((n >> i) & 1))) << i);
                        g[m] = f[src] ^ o[0];
                    end
                    if (first || g < r.canon) begin
                        r.canon = g;
                        r.perm  = 5'(k);
                        r.neg   = 4'(n);
                        r.oneg  = o[0];
                        first   = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    task automatic accept_job(input vec_t exp);
        int w;
        w = 0;
        while (bus.in_ready !== 1'b1 && w < 2000) begin
            @(posedge clk); #1;
            w++;
        end
        check("accept_in_ready", bus.in_ready, 1);
        bus.tt_in    = exp.tt;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        sb_q.push_back(exp);
        check("in_ready_low_after_accept", bus.in_ready, 0);
    endtask

    task automatic wait_done(input bit chk_lat);
        int lat;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 1000) begin
            @(posedge clk); #1;
            lat++;
        end
        check("out_valid_rise", bus.out_valid, 1);
        if (chk_lat) check("latency", lat, 768);
    endtask

    task automatic check_result();
        vec_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_underflow: got empty queue, expected an entry");
        end else begin
            e = sb_q.pop_front();
            check("canon_tt", bus.canon_tt, e.canon);
            check("perm_idx", bus.perm_idx, e.perm);
            check("neg_mask", bus.neg_mask, e.neg);
            check("out_neg",  bus.out_neg,  e.oneg);
        end
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("out_valid_fall", bus.out_valid, 0);
        check("in_ready_rise",  bus.in_ready,  1);
    endtask

    initial begin
        vec_t e;
        bus.in_valid  = 1'b0;
        bus.tt_in     = '0;
        bus.out_ready = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #20;
        check("rst_in_ready",  bus.in_ready,  1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_canon_tt",  bus.canon_tt,  0);
        check("rst_perm_idx",  bus.perm_idx,  0);
        check("rst_neg_mask",  bus.neg_mask,  0);
        check("rst_out_neg",   bus.out_neg,   0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        vecs[0] = '{16'h0000, 16'h0000, 5'd0,  4'h0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 5'd0,  4'h0, 1'b1};
        vecs[2] = '{16'h8000, 16'h0001, 5'd0,  4'hF, 1'b0};
        vecs[3] = '{16'hAAAA, 16'h00FF, 5'd18, 4'h0, 1'b1};
        vecs[4] = '{16'h0001, 16'h0001, 5'd0,  4'h0, 1'b0};
        vecs[5] = '{16'h7FFF, 16'h0001, 5'd0,  4'hF, 1'b1};
        for (int i = 6; i < NVEC; i++) vecs[i] = ref_canon(16'($urandom));

        for (int i = 0; i < NVEC; i++) begin
            accept_job(vecs[i]);
            wait_done(1'b1);
            check_result();
            handshake();
        end

        // Back-pressure: result held while a new table is offered and refused.
        e = ref_canon(16'h1234);
        accept_job(e);
        wait_done(1'b1);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = (i % 2 == 0);
            bus.tt_in    = 16'h8000;
            @(posedge clk); #1;
            check("bp_in_ready",  bus.in_ready,  0);
            check("bp_out_valid", bus.out_valid, 1);
            check("bp_canon_tt",  bus.canon_tt,  e.canon);
            check("bp_perm_idx",  bus.perm_idx,  e.perm);
            check("bp_neg_mask",  bus.neg_mask,  e.neg);
            check("bp_out_neg",   bus.out_neg,   e.oneg);
        end
        bus.in_valid = 1'b0;
        check_result();
        handshake();
        accept_job('{16'h8000, 16'h0001, 5'd0, 4'hF, 1'b0});
        wait_done(1'b1);
        check_result();
        handshake();

        // Mid-scan reset with in_valid held high during the scan.
        accept_job(ref_canon(16'h1234));
        bus.in_valid = 1'b1;
        bus.tt_in    = 16'hFFFF;
        repeat (300) @(posedge clk);
        #1;
        check("scan_in_ready", bus.in_ready, 0);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_in_ready",  bus.in_ready,  1);
        check("mid_rst_canon_tt",  bus.canon_tt,  0);
        check("mid_rst_perm_idx",  bus.perm_idx,  0);
        check("mid_rst_neg_mask",  bus.neg_mask,  0);
        check("mid_rst_out_neg",   bus.out_neg,   0);
        void'(sb_q.pop_back());
        @(posedge clk); #1;
        rst_n = 1'b1;
        accept_job('{16'h8000, 16'h0001, 5'd0, 4'hF, 1'b0});
        wait_done(1'b1);
        check_result();
        handshake();

        check("scoreboard_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, expected finish before 2ms");
        $fatal(1, "watchdog timeout");
    end

endmodule
